// File: rtl/data_qsync_pkg.sv
// Shared helpers for the quasi-synchronous receive buffer:
// width derivations and parameter legality predicates.
package data_qsync_pkg;

   localparam int depth_min = 2;
   localparam int depth_max = 16;
   localparam int width_max = 1024;

   // Smallest r such that 2**r >= n.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   function automatic int ptr_w(input int depth);
      return (clog2(depth) < 1) ? 1 : clog2(depth);
   endfunction

   // The count must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return clog2(depth + 1);
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= depth_min) && (depth <= depth_max)
         && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic bit af_ok(input int af_level, input int depth);
      return (af_level >= 1) && (af_level <= depth);
   endfunction

   function automatic bit width_ok(input int width);
      return (width >= 1) && (width <= width_max);
   endfunction

endpackage

// File: rtl/data_qsync_rx_buf_mem.sv
// Storage for the receive buffer: depth x width register array,
// one write port, one asynchronous read port, no reset.
module data_qsync_rx_buf_mem
   import data_qsync_pkg::*;
#(
   parameter int width = 8,
   parameter int depth = 4
) (
   input  logic                      clk_d,
   input  logic                      we,
   input  logic [ptr_w(depth)-1:0]   waddr,
   input  logic [width-1:0]          wdata,
   input  logic [ptr_w(depth)-1:0]   raddr,
   output logic [width-1:0]          rdata
);

   logic [width-1:0] mem [depth];

   always_ff @(posedge clk_d) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/data_qsync_rx_buf.sv
// Receive FIFO behind the low-to-high data synchronizer: absorbs strobes,
// presents a show-ahead valid/pop stream, drops on full with sticky flag.
module data_qsync_rx_buf
   import data_qsync_pkg::*;
#(
   parameter int width    = 8,
   parameter int depth    = 4,
   parameter int af_level = 3
) (
   input  logic                      clk_d,
   input  logic                      rst_d_n,
   input  logic                      init_d_n,
   input  logic                      data_avail_d,
   input  logic [width-1:0]          data_d,
   input  logic                      pop_d,
   output logic                      valid_d,
   output logic [width-1:0]          dout_d,
   output logic                      empty_d,
   output logic                      full_d,
   output logic                      almost_full_d,
   output logic [cnt_w(depth)-1:0]   count_d,
   output logic                      overflow_d,
   input  logic                      clr_ovf_d
);

   localparam int pw = ptr_w(depth);
   localparam int cw = cnt_w(depth);
   localparam logic [cw-1:0] cnt_full = cw'(depth);
   localparam logic [cw-1:0] cnt_af   = cw'(af_level);

   if (!depth_ok(depth)) begin : g_bad_depth
      $error("data_qsync_rx_buf: depth must be a power of 2 in 2..16");
   end
   if (!af_ok(af_level, depth)) begin : g_bad_af
      $error("data_qsync_rx_buf: af_level must be in 1..depth");
   end
   if (!width_ok(width)) begin : g_bad_width
      $error("data_qsync_rx_buf: width must be in 1..1024");
   end

   logic [pw-1:0]    wr_ptr;
   logic [pw-1:0]    rd_ptr;
   logic [cw-1:0]    count;
   logic             ovf;
   logic [width-1:0] head;
   logic             empty;
   logic             full;
   logic             pop_eff;
   logic             push;
   logic             drop;

   assign empty   = (count == '0);
   assign full    = (count == cnt_full);
   // A pop on an empty buffer is ignored, so there is no bypass path.
   assign pop_eff = pop_d & ~empty;
   // When full, a same-cycle pop frees the slot the push will use.
   assign push    = data_avail_d & (~full | pop_eff);
   assign drop    = data_avail_d & full & ~pop_eff;

   always_ff @(posedge clk_d or negedge rst_d_n) begin
      if (!rst_d_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (!init_d_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else begin
         if (push)    wr_ptr <= wr_ptr + pw'(1);
         if (pop_eff) rd_ptr <= rd_ptr + pw'(1);
         if (push & ~pop_eff)      count <= count + cw'(1);
         else if (pop_eff & ~push) count <= count - cw'(1);
         // A new drop outranks a clear in the same cycle.
         if (drop)           ovf <= 1'b1;
         else if (clr_ovf_d) ovf <= 1'b0;
      end
   end

   data_qsync_rx_buf_mem #(
      .width (width),
      .depth (depth)
   ) u_mem (
      .clk_d (clk_d),
      .we    (push & init_d_n),
      .waddr (wr_ptr),
      .wdata (data_d),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign valid_d       = ~empty;
   assign dout_d        = empty ? '0 : head;
   assign empty_d       = empty;
   assign full_d        = full;
   assign almost_full_d = (count >= cnt_af);
   assign count_d       = count;
   assign overflow_d    = ovf;

endmodule

// File: tb/tb_data_qsync_rx_buf.sv
// Randomized scoreboard bench for data_qsync_rx_buf: a queue-based
// reference model predicts popped words and status every cycle.
module tb_data_qsync_rx_buf;

   localparam int width    = 8;
   localparam int depth    = 4;
   localparam int af_level = 3;

   logic       clk_d        = 1'b0;
   logic       rst_d_n      = 1'b0;
   logic       init_d_n     = 1'b1;
   logic       data_avail_d = 1'b0;
   logic [7:0] data_d       = 8'h00;
   logic       pop_d        = 1'b0;
   logic       clr_ovf_d    = 1'b0;
   logic       valid_d;
   logic [7:0] dout_d;
   logic       empty_d;
   logic       full_d;
   logic       almost_full_d;
   logic [2:0] count_d;
   logic       overflow_d;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] mq[$];
   logic [7:0] sb_q[$];
   bit         movf    = 1'b0;
   bit         mon_en  = 1'b0;
   int         exp_cnt = 0;
   logic [7:0] exp_head = 8'h00;
   bit         exp_ovf = 1'b0;

   data_qsync_rx_buf #(
      .width    (width),
      .depth    (depth),
      .af_level (af_level)
   ) dut (
      .clk_d         (clk_d),
      .rst_d_n       (rst_d_n),
      .init_d_n      (init_d_n),
      .data_avail_d  (data_avail_d),
      .data_d        (data_d),
      .pop_d         (pop_d),
      .valid_d       (valid_d),
      .dout_d        (dout_d),
      .empty_d       (empty_d),
      .full_d        (full_d),
      .almost_full_d (almost_full_d),
      .count_d       (count_d),
      .overflow_d    (overflow_d),
      .clr_ovf_d     (clr_ovf_d)
   );

   always #5 clk_d = ~clk_d;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Mid-cycle monitor: status against the model snapshot, popped
   // words against the scoreboard queue.
   always @(negedge clk_d) begin
      if (mon_en) begin
         chk("count", 32'(count_d), 32'(exp_cnt));
         chk("valid", 32'(valid_d), 32'(exp_cnt != 0));
         chk("empty", 32'(empty_d), 32'(exp_cnt == 0));
         chk("full", 32'(full_d), 32'(exp_cnt == depth));
         chk("almost_full", 32'(almost_full_d), 32'(exp_cnt >= af_level));
         chk("head", 32'(dout_d), 32'(exp_head));
         chk("overflow", 32'(overflow_d), 32'(exp_ovf));
         if (pop_d && valid_d && init_d_n) begin
            if (sb_q.size() == 0) chk("pop_unexpected", 32'd1, 32'd0);
            else chk("pop_data", 32'(dout_d), 32'(sb_q.pop_front()));
         end
      end
   end

   // Called just after a rising edge; drives one cycle and advances model.
   task automatic step(input bit av, input logic [7:0] d, input bit p,
                       input bit clr, input bit ini = 1'b1);
      bit drop;
      drop     = 1'b0;
      exp_cnt  = mq.size();
      exp_head = (mq.size() > 0) ? mq[0] : 8'h00;
      exp_ovf  = movf;
      data_avail_d = av;
      data_d       = d;
      pop_d        = p;
      clr_ovf_d    = clr;
      init_d_n     = ini;
      if (!ini) begin
         mq.delete();
         movf = 1'b0;
      end else begin
         if (p && mq.size() > 0) sb_q.push_back(mq.pop_front());
         if (av) begin
            if (mq.size() < depth) mq.push_back(d);
            else drop = 1'b1;
         end
         if (drop) movf = 1'b1;
         else if (clr) movf = 1'b0;
      end
      @(posedge clk_d);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_valid"}, 32'(valid_d), 32'd0);
      chk({tag, "_dout"}, 32'(dout_d), 32'd0);
      chk({tag, "_empty"}, 32'(empty_d), 32'd1);
      chk({tag, "_full"}, 32'(full_d), 32'd0);
      chk({tag, "_af"}, 32'(almost_full_d), 32'd0);
      chk({tag, "_count"}, 32'(count_d), 32'd0);
      chk({tag, "_ovf"}, 32'(overflow_d), 32'd0);
   endtask

   task automatic async_reset();
      mon_en       = 1'b0;
      data_avail_d = 1'b0;
      pop_d        = 1'b0;
      clr_ovf_d    = 1'b0;
      init_d_n     = 1'b1;
      #1 rst_d_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      mq.delete();
      sb_q.delete();
      movf = 1'b0;
      @(posedge clk_d);
      #1 rst_d_n = 1'b1;
      mon_en = 1'b1;
   endtask

   task automatic fill4();
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      step(1'b1, 8'h44, 1'b0, 1'b0);
   endtask

   initial begin
      repeat (2) @(posedge clk_d);
      #1;
      check_reset_outputs("por");
      rst_d_n = 1'b1;
      mon_en  = 1'b1;

      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 8'hA3, 1'b0, 1'b0);
      async_reset();

      step(1'b1, 8'hA1, 1'b0, 1'b0);
      step(1'b1, 8'hA2, 1'b0, 1'b0);
      step(1'b1, 8'hA3, 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
      idle();

      fill4();
      step(1'b1, 8'h55, 1'b0, 1'b0);
      idle();
      repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
      idle();

      fill4();
      step(1'b1, 8'h66, 1'b1, 1'b0);
      repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
      idle();

      step(1'b1, 8'hA5, 1'b1, 1'b0);
      idle();
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'hB1, 1'b0, 1'b0);
      step(1'b1, 8'hB2, 1'b0, 1'b0);
      step(1'b1, 8'hB3, 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      idle();
      step(1'b0, 8'h00, 1'b0, 1'b1);
      repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0);
      idle();

      repeat (64) step(1'b1, 8'($urandom), 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      idle();

      repeat (400) begin
         step(1'($urandom_range(0, 1)), 8'($urandom),
              1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 31) != 0));
      end

      repeat (depth + 1) step(1'b0, 8'h00, 1'b1, 1'b0);
      idle();
      chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/data_qsync_rx_buf.md
# data_qsync_rx_buf

Destination-domain receive buffer placed directly downstream of the low-to-high quasi-synchronous data synchronizer. It captures every single-cycle `data_avail_d` strobe with its `data_d` word into a small FIFO, because the synchronizer has no backpressure. It presents the words to the consumer as a show-ahead valid/pop stream. Words that arrive while the buffer is full are dropped, and a sticky overflow flag is raised.

## Interface
Parameters:
- `width`, 8: data word width, 1..1024.
- `depth`, 4: FIFO entries, power of 2, 2..16.
- `af_level`, 3: `almost_full_d` asserts when count >= `af_level`; range 1..`depth`.

Ports:
- `clk_d`, in, 1: destination clock; single clock for the whole block.
- `rst_d_n`, in, 1: asynchronous active-low reset.
- `init_d_n`, in, 1: synchronous active-low init; same effect as reset.
- `data_avail_d`, in, 1: one-cycle strobe from the synchronizer; push request.
- `data_d`, in, `width`: word qualified by `data_avail_d`.
- `pop_d`, in, 1: consumer takes the head word this cycle.
- `valid_d`, out, 1: head word available (= !empty).
- `dout_d`, out, `width`: head word; 0 when empty.
- `empty_d`, out, 1: FIFO empty.
- `full_d`, out, 1: count == `depth`.
- `almost_full_d`, out, 1: count >= `af_level`.
- `count_d`, out, clog2(`depth`+1): number of stored words.
- `overflow_d`, out, 1: sticky; a word was dropped.
- `clr_ovf_d`, in, 1: synchronous clear of `overflow_d`.

## Operation
- State: write pointer and read pointer, each log2(`depth`) bits and wrapping modulo `depth`; a count register; storage array; overflow flag.
- Push: `data_avail_d` = 1 and (not full, or full with an effective pop) → write `data_d` at wr_ptr, increment wr_ptr.
- Effective pop: `pop_d` = 1 and `valid_d` = 1. Increments rd_ptr. A pop while empty is ignored and has no side effects.
- Count: increments on push only, decrements on effective pop only, holds on both or neither.
- Full with simultaneous push and effective pop: both occur; count stays `depth`; no overflow.
- Full with push and no effective pop: the word is dropped. Storage, pointers and count are unchanged, and `overflow_d` sets.
- Empty with simultaneous push and pop: the pop is ignored (no bypass) and the push is accepted; count becomes 1.
- Overflow flag:
  - `clr_ovf_d` and a new drop in the same cycle → `overflow_d` stays 1 (set wins).
  - Otherwise `clr_ovf_d` clears it.
- Init: `init_d_n` = 0 has priority over push, pop and clear. Pointers, count and overflow go to 0. Storage contents are don't-care.
- Reset: `rst_d_n` = 0 asynchronously forces the same state.
- Reset values of outputs: `valid_d` 0, `dout_d` 0, `empty_d` 1, `full_d` 0, `almost_full_d` 0, `count_d` 0, `overflow_d` 0.

## Timing
- All state updates on the rising edge of `clk_d`.
- Outputs are combinational from registers only; there is no input-to-output combinational path.
- Write latency: a strobe sampled at edge k into an empty FIFO → `valid_d` = 1 and `dout_d` = that word after edge k. Minimum fill-to-visible latency is 1 cycle.
- Pop at edge k → the next word, or `valid_d` = 0, is presented after edge k.
- Throughput: 1 push and 1 pop per cycle sustained. `data_avail_d` may assert on consecutive cycles.
- `overflow_d` rises the cycle after the dropping edge.
- Flags `full_d`, `empty_d` and `almost_full_d` are derived from `count_d` and change in the same cycle as it.

## Structure
- Shared package `data_qsync_pkg`:
  - clog2-style width function.
  - Pointer-width and count-width localparam derivations.
  - Parameter-legality checks (power-of-2 depth, `af_level` range), reported as elaboration errors.
- One sub-module, `data_qsync_rx_buf_mem`: a `depth` x `width` register array with one write port and one asynchronous read port, no reset on storage.
- The top level holds the pointers, count, overflow logic and the output gating that forces `dout_d` to 0 when empty.

## Test plan
- Reset and init: assert `rst_d_n` mid-stream with 3 words stored → all outputs return to reset values immediately. Repeat with `init_d_n` at the next edge → same result, with push ignored in that cycle.
- Burst fill: 4 consecutive strobes carrying 0x11, 0x22, 0x33, 0x44 with no pop →
  - `count_d` goes 1, 2, 3, 4; `almost_full_d` rises at count 3; `full_d` rises at count 4.
  - `dout_d` stays 0x11 throughout.
- Overflow: fill to 4, strobe 0x55 with no pop → 0x55 is dropped, `overflow_d` = 1, count stays 4. Pop four times → 0x11..0x44 come out in order, then `valid_d` = 0 and `dout_d` = 0.
- Full with simultaneous push and pop: at count 4, pop plus strobe 0x66 → count 4, no overflow, new head 0x22, and 0x66 is output after 0x44.
- Empty with simultaneous push and pop: pop plus strobe 0xA5 → pop ignored, count 1, `dout_d` = 0xA5. Then `clr_ovf_d` in the same cycle as a drop → `overflow_d` stays 1.
- Streaming: a strobe and a pop every cycle for 64 cycles with random data → output sequence equals input sequence, count stays at 1, no overflow.
